pipe_hazard_ctrl: RTL and testbench

Pipeline control block for the 5-stage PL_CPU that drives the enable/flush side of the ID/EX and IF/ID pipeline registers and the PC. It observes the instruction in ID and the instruction in EX, and:
- inserts load-use bubbles,
- freezes the front end while a multi-cycle multiply occupies EX,
- squashes wrong-path instructions on a taken branch.

It also keeps saturating stall/flush event counters for performance debug.

---
 rtl/pl_cpu_pkg.sv | 15 +
 rtl/sat_counter.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pl_cpu_pkg.sv
// Shared PL_CPU definitions: hazard-controller states, register width and the
// all-zero control word that both pipeline registers load as a bubble.
package pl_cpu_pkg;

  localparam int unsigned RegWDefault = 5;

  // Hazard controller states
  localparam logic [1:0] StRun     = 2'd0;
  localparam logic [1:0] StLuStall = 2'd1;
  localparam logic [1:0] StMulWait = 2'd2;

  localparam int unsigned CtrlW = 16;
  localparam logic [CtrlW-1:0] BubbleCtrl = '0;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Enable/flush control for the IF/ID and ID/EX registers and the PC: load-use bubbles,
// multiply freeze and taken-branch squash, plus saturating stall/flush counters.
module pipe_hazard_ctrl
  import pl_cpu_pkg::*;
#(
  parameter int unsigned REG_W   = RegWDefault,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_valid,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_mul_start,
  input  logic             ex_branch_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned MulCntW = $clog2(MUL_LAT);
  localparam logic [MulCntW-1:0] MulInit = MulCntW'(MUL_LAT - 2);

  logic [1:0]         state_q, state_d;
  logic [MulCntW-1:0] mul_cnt_q, mul_cnt_d;
  logic               load_use;
  logic               flush_evt;

  // r0 is hard-wired zero, so a load targeting it can never create a hazard
  assign load_use = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
                    ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));

  always_comb begin
    state_d    = state_q;
    mul_cnt_d  = mul_cnt_q;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    flush_evt  = 1'b0;
    if (Rst) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = StRun;
      mul_cnt_d  = '0;
    end else begin
      case (state_q)
        StRun: begin
          if (ex_valid && ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_evt  = 1'b1;
          end else if (ex_valid && ex_mul_start) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            idex_en = 1'b0;
            if (MUL_LAT > 2) begin
              state_d   = StMulWait;
              mul_cnt_d = MulInit;
            end
          end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            state_d    = StLuStall;
          end
        end
        StLuStall: state_d = StRun;
        StMulWait: begin
          // EX still holds the multiply, so every EX-side request is ignored here
          pc_en     = 1'b0;
          ifid_en   = 1'b0;
          idex_en   = 1'b0;
          mul_cnt_d = mul_cnt_q - MulCntW'(1);
          if (mul_cnt_q == MulCntW'(1)) begin
            state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= StRun;
      mul_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .Clk  (Clk),
    .Rst  (Rst),
    .inc  (~pc_en),
    .count(stall_cnt)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_flush_cnt (
    .Clk  (Clk),
    .Rst  (Rst),
    .inc  (flush_evt),
    .count(flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (default and MUL_LAT=2/CNT_W=2) share stimulus
// and are checked every cycle against a freeze-count model plus literal spot checks.
module tb_pipe_hazard_ctrl;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       id_valid, id_uses_rs, id_uses_rt;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       ex_valid, ex_mem_read, ex_mul_start, ex_branch_taken;

  logic        pc_en_a, ifid_en_a, ifid_flush_a, idex_en_a, idex_flush_a;
  logic [15:0] stall_cnt_a, flush_cnt_a;
  logic        pc_en_b, ifid_en_b, ifid_flush_b, idex_en_b, idex_flush_b;
  logic [1:0]  stall_cnt_b, flush_cnt_b;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 Clk = ~Clk;

  pipe_hazard_ctrl #(.REG_W(5), .MUL_LAT(4), .CNT_W(16)) dut_a (
    .Clk(Clk), .Rst(Rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_mul_start(ex_mul_start),
    .ex_branch_taken(ex_branch_taken), .pc_en(pc_en_a), .ifid_en(ifid_en_a),
    .ifid_flush(ifid_flush_a), .idex_en(idex_en_a), .idex_flush(idex_flush_a),
    .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
  );

  pipe_hazard_ctrl #(.REG_W(5), .MUL_LAT(2), .CNT_W(2)) dut_b (
    .Clk(Clk), .Rst(Rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_mul_start(ex_mul_start),
    .ex_branch_taken(ex_branch_taken), .pc_en(pc_en_b), .ifid_en(ifid_en_b),
    .ifid_flush(ifid_flush_b), .idex_en(idex_en_b), .idex_flush(idex_flush_b),
    .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
  );

  logic [4:0] out_v [2];
  int         sc_v [2];
  int         fc_v [2];
  assign out_v[0] = {pc_en_a, ifid_en_a, ifid_flush_a, idex_en_a, idex_flush_a};
  assign out_v[1] = {pc_en_b, ifid_en_b, ifid_flush_b, idex_en_b, idex_flush_b};
  assign sc_v[0] = int'(stall_cnt_a);
  assign sc_v[1] = int'(stall_cnt_b);
  assign fc_v[0] = int'(flush_cnt_a);
  assign fc_v[1] = int'(flush_cnt_b);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: remaining frozen cycles after a multiply, pending bubble after a load-use
  int lat [2]  = '{4, 2};
  int cmax [2] = '{65535, 3};
  int frozen [2] = '{0, 0};
  bit bubble [2] = '{1'b0, 1'b0};
  int scnt [2] = '{0, 0};
  int fcnt [2] = '{0, 0};

  always @(negedge Clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        bit pc, ie, ifl, de, dfl, lu, nb, inc_f;
        int nf;
        pc = 1; ie = 1; ifl = 0; de = 1; dfl = 0; nb = 0; inc_f = 0; nf = frozen[i];
        lu = ex_valid && ex_mem_read && (ex_rd != 0) && id_valid &&
             ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
        if (Rst) begin
          ifl = 1; dfl = 1; nf = 0;
        end else if (frozen[i] > 0) begin
          pc = 0; ie = 0; de = 0; nf = frozen[i] - 1;
        end else if (bubble[i]) begin
          nb = 0;
        end else if (ex_valid && ex_branch_taken) begin
          ifl = 1; dfl = 1; inc_f = 1;
        end else if (ex_valid && ex_mul_start) begin
          pc = 0; ie = 0; de = 0; nf = lat[i] - 2;
        end else if (lu) begin
          pc = 0; ie = 0; dfl = 1; nb = 1;
        end
        chk($sformatf("pc_en[%0d]", i), int'(out_v[i][4]), int'(pc));
        chk($sformatf("ifid_en[%0d]", i), int'(out_v[i][3]), int'(ie));
        chk($sformatf("ifid_flush[%0d]", i), int'(out_v[i][2]), int'(ifl));
        chk($sformatf("idex_en[%0d]", i), int'(out_v[i][1]), int'(de));
        chk($sformatf("idex_flush[%0d]", i), int'(out_v[i][0]), int'(dfl));
        chk($sformatf("stall_cnt[%0d]", i), sc_v[i], scnt[i]);
        chk($sformatf("flush_cnt[%0d]", i), fc_v[i], fcnt[i]);
        if (Rst) begin
          scnt[i] = 0; fcnt[i] = 0;
        end else begin
          if (!pc && scnt[i] < cmax[i]) scnt[i]++;
          if (inc_f && fcnt[i] < cmax[i]) fcnt[i]++;
        end
        frozen[i] = nf;
        bubble[i] = nb;
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    ex_valid = 0; ex_rd = 0; ex_mem_read = 0; ex_mul_start = 0; ex_branch_taken = 0;
  endtask

  // Load in EX writing rd, ID reading rs==rd
  task automatic set_lu(input logic [4:0] rd);
    idle();
    ex_valid = 1; ex_mem_read = 1; ex_rd = rd;
    id_valid = 1; id_rs = rd; id_uses_rs = 1;
  endtask

  initial begin
    idle();
    Rst = 1;
    step();
    chk_en = 1;
    #2;
    chk("reset_pc_en", int'(pc_en_a), 1);
    chk("reset_ifid_flush", int'(ifid_flush_a), 1);
    chk("reset_idex_flush", int'(idex_flush_a), 1);
    step();
    chk("reset_stall_cnt", int'(stall_cnt_a), 0);
    Rst = 0;
    step();

    // Load-use on rs
    set_lu(5'd5);
    #2;
    chk("lu_pc_en", int'(pc_en_a), 0);
    chk("lu_ifid_en", int'(ifid_en_a), 0);
    chk("lu_idex_flush", int'(idex_flush_a), 1);
    step();
    ex_valid = 0;
    #2;
    chk("lu_bubble_pc_en", int'(pc_en_a), 1);
    chk("lu_bubble_idex_flush", int'(idex_flush_a), 0);
    chk("lu_stall_cnt", int'(stall_cnt_a), 1);
    step();

    // No false stalls
    set_lu(5'd0); #2; chk("rd0_pc_en", int'(pc_en_a), 1); step();
    set_lu(5'd5); id_uses_rs = 0; #2; chk("nouse_pc_en", int'(pc_en_a), 1); step();
    set_lu(5'd5); ex_mem_read = 0; #2; chk("noload_pc_en", int'(pc_en_a), 1); step();
    set_lu(5'd5); id_valid = 0; #2; chk("noidv_pc_en", int'(pc_en_a), 1); step();

    // Load-use on rt
    idle();
    ex_valid = 1; ex_mem_read = 1; ex_rd = 5'd7;
    id_valid = 1; id_rt = 5'd7; id_uses_rt = 1; id_rs = 5'd3; id_uses_rs = 1;
    #2; chk("lu_rt_pc_en", int'(pc_en_a), 0);
    step();
    idle(); step();

    // Multiply, then branch + load-use match while frozen
    idle(); ex_valid = 1; ex_mul_start = 1;
    #2; chk("mul0_pc_en", int'(pc_en_a), 0); chk("mul0_b_pc_en", int'(pc_en_b), 0);
    step();
    set_lu(5'd5); ex_branch_taken = 1;
    #2; chk("mul1_pc_en", int'(pc_en_a), 0); chk("mul1_b_ifid_flush", int'(ifid_flush_b), 1);
    step();
    #2; chk("mul2_pc_en", int'(pc_en_a), 0); chk("mul2_ifid_flush", int'(ifid_flush_a), 0);
    step();
    idle();
    #2;
    chk("mul3_pc_en", int'(pc_en_a), 1);
    chk("mul_stall_cnt", int'(stall_cnt_a), 5);
    chk("mul_flush_cnt", int'(flush_cnt_a), 0);
    chk("mul_b_flush_cnt", int'(flush_cnt_b), 2);
    step();

    // Branch beats a simultaneous load-use
    set_lu(5'd5); ex_branch_taken = 1;
    #2;
    chk("br_pc_en", int'(pc_en_a), 1);
    chk("br_ifid_flush", int'(ifid_flush_a), 1);
    chk("br_idex_flush", int'(idex_flush_a), 1);
    step();
    idle();
    #2;
    chk("br_flush_cnt", int'(flush_cnt_a), 1);
    chk("br_stall_cnt", int'(stall_cnt_a), 5);
    step();

    // Reset during MUL_WAIT
    idle(); ex_valid = 1; ex_mul_start = 1; step();
    idle(); Rst = 1;
    #2;
    chk("rstmul_pc_en", int'(pc_en_a), 1);
    chk("rstmul_ifid_flush", int'(ifid_flush_a), 1);
    step();
    #2; chk("rstmul_stall_cnt", int'(stall_cnt_a), 0); chk("rstmul_flush_cnt", int'(flush_cnt_a), 0);
    step();
    Rst = 0;
    #2; chk("rstmul_after_pc_en", int'(pc_en_a), 1); chk("rstmul_after_ifid_flush", int'(ifid_flush_a), 0);
    step();

    // Reset during LU_STALL
    set_lu(5'd9); step();
    idle(); Rst = 1; step();
    Rst = 0;
    #2; chk("rstlu_pc_en", int'(pc_en_a), 1);
    step();

    // Saturation: four load-use events
    for (int k = 0; k < 4; k++) begin
      set_lu(5'd12); step();
      idle(); step();
    end
    #2;
    chk("sat_b_stall_cnt", int'(stall_cnt_b), 3);
    chk("sat_a_stall_cnt", int'(stall_cnt_a), 4);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
